phy_config_sequencer: RTL and testbench
=======================================

PHY_CONFIG_SEQUENCER -- requirements
Module: phy_config_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; the ports are named clk and reset.
REQ-002 Parameters (name, default, meaning) SHALL be:
- CFG_COUNT, 1, number of config writes (1..8).
- CFG_ADDR, {5'h18}, packed CFG_COUNT x 5-bit register addresses; entry 0 in the LSBs.
- CFG_DATA, {16'h0030}, packed CFG_COUNT x 16-bit write data; entry 0 in the LSBs.
- STATUS_ADDR, 5'h01, polled status register.
- LINK_BIT, 2, bit index of link status in rdata.
- STARTUP_CYCLES, 1000, delay before the first write.
- POLL_CYCLES, 1000000, delay between status reads.
- TIMEOUT_CYCLES, 100000, response wait limit.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, system clock (udp_sys_clk domain).
- reset, in, 1, synchronous active-high reset.
- restart, in, 1, single-cycle request to rerun the configuration.
- m_axil_awaddr, out, 5, write register address.
- m_axil_awvalid, out, 1, write address valid.
- m_axil_awready, in, 1, write address ready.
- m_axil_wdata, out, 16, write data.
- m_axil_wvalid, out, 1, write data valid.
- m_axil_wready, in, 1, write data ready.
- m_axil_bvalid, in, 1, write response valid.
- m_axil_bready, out, 1, write response ready.
- m_axil_araddr, out, 5, read register address.
- m_axil_arvalid, out, 1, read address valid.
- m_axil_arready, in, 1, read address ready.
- m_axil_rdata, in, 16, read data.
- m_axil_rvalid, in, 1, read data valid.
- m_axil_rready, out, 1, read data ready.
- config_done, out, 1, all config writes completed.
- link_up, out, 1, last sampled link bit.
- error, out, 1, sticky response-timeout flag.
- status_reg, out, 16, last read status register value.

Function
REQ-004 The FSM SHALL have the states START_WAIT, WR_REQ, WR_RESP, POLL_WAIT, RD_REQ and RD_RESP.
REQ-005 START_WAIT SHALL count STARTUP_CYCLES clocks, then enter WR_REQ with index 0.
REQ-006 In WR_REQ:
- awaddr = CFG_ADDR[index] and wdata = CFG_DATA[index].
- awvalid and wvalid are asserted together on entry.
- Each valid deasserts in the cycle after its own ready&valid handshake, independently.
- The FSM enters WR_RESP once both handshakes have completed, including when both complete in the same cycle.
REQ-007 In WR_RESP:
- bready = 1.
- On bvalid, if index = CFG_COUNT-1: set config_done and enter POLL_WAIT with the counter cleared.
- On bvalid otherwise: increment index and enter WR_REQ.
REQ-008 POLL_WAIT SHALL count POLL_CYCLES clocks, then enter RD_REQ.
REQ-009 RD_REQ SHALL drive araddr = STATUS_ADDR and arvalid = 1 until arready, then enter RD_RESP.
REQ-010 In RD_RESP:
- rready = 1.
- On rvalid: status_reg <= rdata and link_up <= rdata[LINK_BIT], both registered the same cycle, then enter POLL_WAIT.
REQ-011 A timeout counter SHALL run only in WR_RESP and RD_RESP; on reaching TIMEOUT_CYCLES-1 without a response:
- Set error (sticky until reset).
- Treat the transaction as complete and take the normal next-state transition.
- link_up and status_reg are unchanged.
REQ-012 Valid signals SHALL never deassert before their handshake; the REQ states have no timeout.
REQ-013 restart SHALL be latched as pending in any state.
REQ-014 Pending restart SHALL be honored only on entry to, or while in, POLL_WAIT:
- Clear config_done and the pending flag.
- Set index to 0 and enter WR_REQ next cycle, skipping STARTUP_CYCLES.
- link_up, status_reg and error are retained.
REQ-015 restart asserted while already pending SHALL be absorbed, giving one rerun only.
REQ-016 All counters SHALL be wide enough for their parameter; index SHALL be 3 bits; CFG_COUNT > 8 is illegal (elaboration assertion).
REQ-017 The AXI-lite outputs SHALL be registered; outputs with no valid asserted are don't-care but driven to 0.

Reset
REQ-018 During reset the module SHALL drive:
- state = START_WAIT, with all counters and index = 0.
- All valid/ready outputs = 0.
- config_done = 0, link_up = 0, error = 0, status_reg = 16'h0000.
- restart pending cleared.
REQ-019 Reset asserted mid-transaction SHALL abort immediately, dropping valids the next cycle, and restart from START_WAIT.

Verification
REQ-020 Default parameters with an always-ready slave and bvalid 2 cycles after the handshake SHALL produce:
- Exactly one write with awaddr = 5'h18 and wdata = 16'h0030.
- config_done = 1 three cycles after the handshake.
- First arvalid with araddr = 5'h01 after POLL_CYCLES.
REQ-021 CFG_COUNT = 3 with awready delayed 4 cycles and wready 1 cycle SHALL produce three ordered writes, each with wvalid dropping before awvalid, and config_done only after the third bvalid.
REQ-022 A read returning rdata = 16'h0004 SHALL give link_up = 1 and status_reg = 16'h0004; a next read of 16'h0000 SHALL give link_up = 0.
REQ-023 A bvalid withheld in WR_RESP SHALL set error after TIMEOUT_CYCLES, after which the sequence continues and config_done = 1.
REQ-024 A restart pulse during WR_RESP SHALL give no effect until POLL_WAIT, then config_done = 0 and a rewrite of entry 0; two pulses SHALL give one rerun.
REQ-025 Reset asserted while awvalid = 1 SHALL give awvalid = 0 the next cycle and all outputs at their reset values.

Source files
------------

// File: rtl/phy_config_sequencer.sv
// phy_config_sequencer: AXI-lite PHY register write sequence followed by periodic link-status polling
module phy_config_sequencer #(
  parameter int CFG_COUNT = 1,
  parameter logic [CFG_COUNT*5-1:0] CFG_ADDR = {5'h18},
  parameter logic [CFG_COUNT*16-1:0] CFG_DATA = {16'h0030},
  parameter logic [4:0] STATUS_ADDR = 5'h01,
  parameter int LINK_BIT = 2,
  parameter int STARTUP_CYCLES = 1000,
  parameter int POLL_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  output logic [4:0]  m_axil_awaddr,
  output logic        m_axil_awvalid,
  input  logic        m_axil_awready,
  output logic [15:0] m_axil_wdata,
  output logic        m_axil_wvalid,
  input  logic        m_axil_wready,
  input  logic        m_axil_bvalid,
  output logic        m_axil_bready,
  output logic [4:0]  m_axil_araddr,
  output logic        m_axil_arvalid,
  input  logic        m_axil_arready,
  input  logic [15:0] m_axil_rdata,
  input  logic        m_axil_rvalid,
  output logic        m_axil_rready,
  output logic        config_done,
  output logic        link_up,
  output logic        error,
  output logic [15:0] status_reg
);
  localparam logic [2:0] START_WAIT = 3'd0, WR_REQ = 3'd1, WR_RESP = 3'd2,
                         POLL_WAIT = 3'd3, RD_REQ = 3'd4, RD_RESP = 3'd5;
  localparam int CMAX = STARTUP_CYCLES > POLL_CYCLES ? STARTUP_CYCLES : POLL_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  if (CFG_COUNT < 1 || CFG_COUNT > 8) begin : g_bad_cfg_count
    $error("CFG_COUNT must be in 1..8");
  end

  logic [2:0]    st_q, st_d, idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          pend_q, pend_d, done_q, done_d, link_q, link_d, err_q, err_d;
  logic [15:0]   status_q, status_d, wdata_q, wdata_d;
  logic [4:0]    awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic          aw_q, aw_d, w_q, w_d, bready_q, bready_d, ar_q, ar_d, rready_q, rready_d;
  logic          tout, b_hs, r_hs;

  always_comb begin
    st_d = st_q;
    idx_d = idx_q;
    done_d = done_q;
    err_d = err_q;
    link_d = link_q;
    status_d = status_q;
    pend_d = pend_q | restart;
    tout = tcnt_q == TW'(TIMEOUT_CYCLES - 1);
    b_hs = m_axil_bvalid & bready_q;
    r_hs = m_axil_rvalid & rready_q;
    case (st_q)
      START_WAIT: if (cnt_q == CW'(STARTUP_CYCLES - 1)) begin
        st_d = WR_REQ;
        idx_d = '0;
      end
      WR_REQ: if ((!aw_q || m_axil_awready) && (!w_q || m_axil_wready)) st_d = WR_RESP;
      WR_RESP: if (b_hs || tout) begin
        err_d = err_q | ~b_hs;
        if (idx_q == 3'(CFG_COUNT - 1)) begin
          done_d = 1'b1;
          st_d = POLL_WAIT;
        end else begin
          idx_d = idx_q + 3'd1;
          st_d = WR_REQ;
        end
      end
      // a pending restart takes priority over the poll timer and skips the startup delay
      POLL_WAIT: if (pend_d) begin
        pend_d = 1'b0;
        done_d = 1'b0;
        idx_d = '0;
        st_d = WR_REQ;
      end else if (cnt_q == CW'(POLL_CYCLES - 1)) st_d = RD_REQ;
      RD_REQ: if (ar_q && m_axil_arready) st_d = RD_RESP;
      RD_RESP: if (r_hs || tout) begin
        err_d = err_q | ~r_hs;
        status_d = r_hs ? m_axil_rdata : status_q;
        link_d = r_hs ? m_axil_rdata[LINK_BIT] : link_q;
        st_d = POLL_WAIT;
      end
      default: st_d = START_WAIT;
    endcase
    cnt_d = (st_q == START_WAIT || st_q == POLL_WAIT) && st_d == st_q ? cnt_q + 1'b1 : '0;
    tcnt_d = (st_q == WR_RESP || st_q == RD_RESP) && st_d == st_q ? tcnt_q + 1'b1 : '0;
    aw_d = st_d == WR_REQ && (st_q != WR_REQ || (aw_q && !m_axil_awready));
    w_d = st_d == WR_REQ && (st_q != WR_REQ || (w_q && !m_axil_wready));
    awaddr_d = aw_d ? CFG_ADDR[5*idx_d +: 5] : '0;
    wdata_d = w_d ? CFG_DATA[16*idx_d +: 16] : '0;
    bready_d = st_d == WR_RESP;
    ar_d = st_d == RD_REQ;
    araddr_d = ar_d ? STATUS_ADDR : '0;
    rready_d = st_d == RD_RESP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= START_WAIT;
      idx_q <= '0;
      cnt_q <= '0;
      tcnt_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      link_q <= 1'b0;
      err_q <= 1'b0;
      status_q <= '0;
      awaddr_q <= '0;
      aw_q <= 1'b0;
      wdata_q <= '0;
      w_q <= 1'b0;
      bready_q <= 1'b0;
      araddr_q <= '0;
      ar_q <= 1'b0;
      rready_q <= 1'b0;
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      tcnt_q <= tcnt_d;
      pend_q <= pend_d;
      done_q <= done_d;
      link_q <= link_d;
      err_q <= err_d;
      status_q <= status_d;
      awaddr_q <= awaddr_d;
      aw_q <= aw_d;
      wdata_q <= wdata_d;
      w_q <= w_d;
      bready_q <= bready_d;
      araddr_q <= araddr_d;
      ar_q <= ar_d;
      rready_q <= rready_d;
    end
  end

  assign m_axil_awaddr = awaddr_q;
  assign m_axil_awvalid = aw_q;
  assign m_axil_wdata = wdata_q;
  assign m_axil_wvalid = w_q;
  assign m_axil_bready = bready_q;
  assign m_axil_araddr = araddr_q;
  assign m_axil_arvalid = ar_q;
  assign m_axil_rready = rready_q;
  assign config_done = done_q;
  assign link_up = link_q;
  assign error = err_q;
  assign status_reg = status_q;
endmodule

// File: tb/tb_phy_config_sequencer.sv
// tb_phy_config_sequencer: scoreboard bench with a delay-configurable AXI-lite slave model
module tb_phy_config_sequencer;
  logic        clk = 1'b0, reset = 1'b1, restart = 1'b0;
  logic [4:0]  m_axil_awaddr, m_axil_araddr;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
  logic        m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_bvalid = 1'b0;
  logic        m_axil_arready = 1'b0, m_axil_rvalid = 1'b0;
  logic [15:0] m_axil_wdata, status_reg;
  logic [15:0] m_axil_rdata = 16'h0000;
  logic        config_done, link_up, error;

  phy_config_sequencer #(
    .CFG_COUNT(3),
    .CFG_ADDR({5'h03, 5'h1F, 5'h18}),
    .CFG_DATA({16'hBEEF, 16'h1234, 16'h0030}),
    .STATUS_ADDR(5'h01),
    .LINK_BIT(2),
    .STARTUP_CYCLES(8),
    .POLL_CYCLES(16),
    .TIMEOUT_CYCLES(12)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .config_done(config_done), .link_up(link_up), .error(error), .status_reg(status_reg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 1;
  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  int b_tgt = 0, r_tgt = 0, n = 0, b0 = 0;
  bit b_hold = 1'b0, order_chk = 1'b0, r_chk = 1'b0;
  logic [15:0] rd_val = 16'h0004;
  logic [16:0] r_exp;
  logic [4:0]  exp_aw[$];
  logic [15:0] exp_w[$];
  logic [16:0] exp_rd[$];
  logic [4:0]  addr_t[3] = '{5'h18, 5'h1F, 5'h03};
  logic [15:0] data_t[3] = '{16'h0030, 16'h1234, 16'hBEEF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected handshake with value %0h, expected none", nm, act);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic pulse();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic push_writes();
    for (int i = 0; i < 3; i++) begin
      exp_aw.push_back(addr_t[i]);
      exp_w.push_back(data_t[i]);
    end
  endtask

  function automatic bit cond(input int s);
    return s == 0 ? m_axil_awvalid : s == 1 ? config_done : s == 2 ? !config_done :
           s == 3 ? m_axil_bready : s == 4 ? m_axil_arvalid : s == 5 ? error :
           s == 6 ? b_n >= b_tgt : r_n >= r_tgt;
  endfunction

  task automatic wait_cond(input string nm, input int s, input int lim, output int cnt);
    cnt = 0;
    while (!cond(s) && cnt < lim) begin
      step();
      cnt++;
    end
    chk(nm, 32'(cond(s)), 1);
  endtask

  // slave model: each ready/valid rises after its configured number of cycles
  initial forever begin
    @(negedge clk);
    m_axil_awready = m_axil_awvalid && aw_c >= aw_dly;
    aw_c = m_axil_awvalid ? aw_c + 1 : 0;
    m_axil_wready = m_axil_wvalid && w_c >= w_dly;
    w_c = m_axil_wvalid ? w_c + 1 : 0;
    m_axil_bvalid = m_axil_bready && !b_hold && b_c >= b_dly;
    b_c = m_axil_bready ? b_c + 1 : 0;
    m_axil_arready = m_axil_arvalid && ar_c >= ar_dly;
    ar_c = m_axil_arvalid ? ar_c + 1 : 0;
    m_axil_rvalid = m_axil_rready && r_c >= r_dly;
    r_c = m_axil_rready ? r_c + 1 : 0;
    m_axil_rdata = rd_val;
  end

  // monitor: handshakes seen here complete on the following rising edge
  initial forever begin
    @(negedge clk);
    #1;
    if (r_chk) begin
      chk("status_reg", 32'(status_reg), 32'(r_exp[15:0]));
      chk("link_up", 32'(link_up), 32'(r_exp[16]));
      r_chk = 1'b0;
    end
    if (m_axil_awvalid && m_axil_awready) begin
      if (order_chk) chk("w_before_aw", w_n, aw_n + 1);
      if (exp_aw.size() == 0) unexp("awaddr", 32'(m_axil_awaddr));
      else chk("awaddr", 32'(m_axil_awaddr), 32'(exp_aw.pop_front()));
      aw_n++;
    end
    if (m_axil_wvalid && m_axil_wready) begin
      if (exp_w.size() == 0) unexp("wdata", 32'(m_axil_wdata));
      else chk("wdata", 32'(m_axil_wdata), 32'(exp_w.pop_front()));
      w_n++;
    end
    if (m_axil_bvalid && m_axil_bready) b_n++;
    if (m_axil_arvalid && m_axil_arready) begin
      chk("araddr", 32'(m_axil_araddr), 32'h01);
      ar_n++;
    end
    if (m_axil_rvalid && m_axil_rready) begin
      r_n++;
      if (exp_rd.size() != 0) begin
        r_exp = exp_rd.pop_front();
        r_chk = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk("rst_awvalid", 32'(m_axil_awvalid), 0);
    chk("rst_wvalid", 32'(m_axil_wvalid), 0);
    chk("rst_bready", 32'(m_axil_bready), 0);
    chk("rst_arvalid", 32'(m_axil_arvalid), 0);
    chk("rst_rready", 32'(m_axil_rready), 0);
    chk("rst_config_done", 32'(config_done), 0);
    chk("rst_link_up", 32'(link_up), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_status_reg", 32'(status_reg), 0);
    push_writes();
    exp_rd.push_back({1'b1, 16'h0004});
    aw_dly = 4; w_dly = 1; b_dly = 2; order_chk = 1'b1;
    reset = 1'b0;
    wait_cond("wait_startup", 0, 100, n);
    chk("startup_cycles", n, 8);
    wait_cond("wait_cfg_done", 1, 300, n);
    chk("b_count_at_done", b_n, 3);
    chk("aw_count_at_done", aw_n, 3);
    wait_cond("wait_first_ar", 4, 100, n);
    chk("poll_cycles", n, 16);
    order_chk = 1'b0;
    r_tgt = 1;
    wait_cond("wait_read1", 7, 100, n);
    step();
    step();
    rd_val = 16'h0000;
    exp_rd.push_back({1'b0, 16'h0000});
    r_tgt = 2;
    wait_cond("wait_read2", 7, 100, n);
    step();
    step();
    rd_val = 16'hFFFB;
    aw_dly = 0; w_dly = 0; b_dly = 1;
    b0 = b_n;
    push_writes();
    push_writes();
    pulse();
    wait_cond("wait_done_clear", 2, 100, n);
    wait_cond("wait_wr_resp", 3, 50, n);
    pulse();
    step();
    pulse();
    b_tgt = b0 + 6;
    wait_cond("wait_rerun", 6, 400, n);
    repeat (3) step();
    chk("done_after_rerun", 32'(config_done), 1);
    repeat (60) step();
    chk("rerun_b_count", b_n - b0, 6);
    chk("rerun_aw_left", exp_aw.size(), 0);
    chk("error_before_timeout", 32'(error), 0);
    b_hold = 1'b1;
    push_writes();
    pulse();
    wait_cond("wait_to_wr_resp", 3, 200, n);
    wait_cond("wait_error", 5, 100, n);
    chk("timeout_cycles", n, 12);
    wait_cond("wait_done_after_to", 1, 300, n);
    chk("error_sticky", 32'(error), 1);
    chk("link_retained", 32'(link_up), 0);
    chk("status_retained", 32'(status_reg), 32'hFFFB);
    chk("timeout_aw_left", exp_aw.size(), 0);
    b_hold = 1'b0;
    aw_dly = 10; w_dly = 10;
    pulse();
    wait_cond("wait_aw_before_reset", 0, 100, n);
    reset = 1'b1;
    step();
    chk("rst2_awvalid", 32'(m_axil_awvalid), 0);
    chk("rst2_wvalid", 32'(m_axil_wvalid), 0);
    chk("rst2_awaddr", 32'(m_axil_awaddr), 0);
    chk("rst2_config_done", 32'(config_done), 0);
    chk("rst2_error", 32'(error), 0);
    chk("rst2_status_reg", 32'(status_reg), 0);
    chk("rst2_arvalid", 32'(m_axil_arvalid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
